// File: rtl/ones_frame_accumulator.sv
// ones_frame_accumulator: sums FRAME_LEN ones counts into a saturating frame total with max/min, handed off over valid/ready.
// Optional ONES_FRAME_THRESH_EN adds a thresh input and a frame_over flag.
module ones_frame_accumulator #(
    parameter int COUNT_WIDTH = 3,
    parameter int FRAME_LEN   = 8,
    parameter int TOTAL_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COUNT_WIDTH-1:0] in_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] frame_total,
    output logic [COUNT_WIDTH-1:0] frame_max,
    output logic [COUNT_WIDTH-1:0] frame_min,
    output logic                   frame_sat
`ifdef ONES_FRAME_THRESH_EN
    ,
    input  logic [TOTAL_WIDTH-1:0] thresh,
    output logic                   frame_over
`endif
);
    localparam logic ACCUM = 1'b0;
    localparam logic HOLD  = 1'b1;
    localparam int IW = $clog2(FRAME_LEN);
    localparam int SW = (TOTAL_WIDTH > COUNT_WIDTH ? TOTAL_WIDTH : COUNT_WIDTH) + 1;
    localparam logic [SW-1:0] TOP = SW'({TOTAL_WIDTH{1'b1}});

    logic                   state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TOTAL_WIDTH-1:0] tot_q, tot_d, tot_n;
    logic [COUNT_WIDTH-1:0] max_q, max_d, max_n, min_q, min_d, min_n;
    logic                   sat_q, sat_d, sat_n;
    logic [SW-1:0]          sum;
    logic                   accept, last, clr, ovf;

    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == HOLD;

    always_comb begin
        accept  = in_valid && state_q == ACCUM;
        last    = accept && idx_q == IW'(FRAME_LEN - 1);
        clr     = state_q == HOLD && out_ready;
        sum     = SW'(tot_q) + SW'(in_count);
        ovf     = sum > TOP;
        tot_n   = ovf ? '1 : sum[TOTAL_WIDTH-1:0];
        max_n   = in_count > max_q ? in_count : max_q;
        min_n   = in_count < min_q ? in_count : min_q;
        sat_n   = sat_q | ovf;
        // accumulators keep the completed frame through HOLD and clear on the handoff
        tot_d   = clr ? '0 : accept ? tot_n : tot_q;
        max_d   = clr ? '0 : accept ? max_n : max_q;
        min_d   = clr ? '1 : accept ? min_n : min_q;
        sat_d   = clr ? 1'b0 : accept ? sat_n : sat_q;
        idx_d   = last ? '0 : accept ? idx_q + 1'b1 : idx_q;
        state_d = last ? HOLD : clr ? ACCUM : state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            idx_q       <= '0;
            tot_q       <= '0;
            max_q       <= '0;
            min_q       <= '1;
            sat_q       <= 1'b0;
            frame_total <= '0;
            frame_max   <= '0;
            frame_min   <= '1;
            frame_sat   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tot_q   <= tot_d;
            max_q   <= max_d;
            min_q   <= min_d;
            sat_q   <= sat_d;
            if (last) begin
                frame_total <= tot_n;
                frame_max   <= max_n;
                frame_min   <= min_n;
                frame_sat   <= sat_n;
            end
        end
    end

`ifdef ONES_FRAME_THRESH_EN
    always_ff @(posedge clk) begin
        if (reset) frame_over <= 1'b0;
        else if (last) frame_over <= tot_n >= thresh;
    end
`endif
endmodule

// File: tb/tb_ones_frame_accumulator.sv
// tb_ones_frame_accumulator: directed frames against a queue-based frame model, for a 6-bit and a 4-bit total build.
module tb_ones_frame_accumulator;
    localparam int N = 8;

    logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0] in_count = '0;
    logic       in_ready, out_valid, sat6, in_ready4, out_valid4, sat4;
    logic [5:0] total6;
    logic [3:0] total4;
    logic [2:0] max6, min6, max4, min4;
`ifdef ONES_FRAME_THRESH_EN
    logic [5:0] thresh6 = 6'd16;
    logic [3:0] thresh4 = 4'd15;
    logic       over6, over4;
`endif

    ones_frame_accumulator dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
        .out_valid(out_valid), .out_ready(out_ready), .frame_total(total6), .frame_max(max6),
        .frame_min(min6), .frame_sat(sat6)
`ifdef ONES_FRAME_THRESH_EN
        , .thresh(thresh6), .frame_over(over6)
`endif
    );

    ones_frame_accumulator #(.TOTAL_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4), .in_count(in_count),
        .out_valid(out_valid4), .out_ready(out_ready), .frame_total(total4), .frame_max(max4),
        .frame_min(min4), .frame_sat(sat4)
`ifdef ONES_FRAME_THRESH_EN
        , .thresh(thresh4), .frame_over(over4)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // frame model: collect accepted counts, evaluate the frame once FRAME_LEN are in
    int q[$];
    int s, mx, mn;
    bit m_hold = 0, m_sat6 = 0, m_sat4 = 0, m_over6 = 0, m_over4 = 0, started = 0;
    int m_total6 = 0, m_total4 = 0, m_max = 0, m_min = 7;

    initial forever begin
        @(posedge clk);
        started = 1;
        if (reset) begin
            q.delete();
            m_hold = 0; m_total6 = 0; m_total4 = 0; m_max = 0; m_min = 7;
            m_sat6 = 0; m_sat4 = 0; m_over6 = 0; m_over4 = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (in_valid) begin
            q.push_back(int'(in_count));
            if (q.size() == N) begin
                s = 0; mx = 0; mn = 7;
                foreach (q[i]) begin
                    s += q[i];
                    if (q[i] > mx) mx = q[i];
                    if (q[i] < mn) mn = q[i];
                end
                m_total6 = s > 63 ? 63 : s;
                m_total4 = s > 15 ? 15 : s;
                m_sat6 = s > 63;
                m_sat4 = s > 15;
                m_max = mx;
                m_min = mn;
`ifdef ONES_FRAME_THRESH_EN
                m_over6 = m_total6 >= int'(thresh6);
                m_over4 = m_total4 >= int'(thresh4);
`endif
                q.delete();
                m_hold = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("in_ready", in_ready, !m_hold);
            chk("out_valid", out_valid, m_hold);
            chk("total6", total6, m_total6);
            chk("max6", max6, m_max);
            chk("min6", min6, m_min);
            chk("sat6", sat6, m_sat6);
            chk("in_ready4", in_ready4, !m_hold);
            chk("out_valid4", out_valid4, m_hold);
            chk("total4", total4, m_total4);
            chk("max4", max4, m_max);
            chk("min4", min4, m_min);
            chk("sat4", sat4, m_sat4);
`ifdef ONES_FRAME_THRESH_EN
            chk("over6", over6, m_over6);
            chk("over4", over4, m_over4);
`endif
            if (out_valid) pulses++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input int gap);
        int n = 0;
        logic r;
        in_valid = 1'b1;
        in_count = c;
        do begin
            r = in_ready;
            step();
            n++;
        end while (!r && n < 100);
        if (!r) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic frame(input logic [2:0] c, input int gap);
        repeat (N) send(c, gap);
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ready_after_take", in_ready, 1);
        chk("valid_after_take", out_valid, 0);
    endtask

    logic [2:0] pat [8] = '{3'd0, 3'd4, 3'd1, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};
    int base;

    initial begin
        repeat (2) step();
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_total", total6, 0);
        chk("rst_max", max6, 0);
        chk("rst_min", min6, 7);
        chk("rst_sat", sat6, 0);
        reset = 1'b0;
        step();

        frame(3'd2, 0);
        chk("f1_valid", out_valid, 1);
        chk("f1_ready", in_ready, 0);
        chk("f1_total", total6, 16);
        chk("f1_max", max6, 2);
        chk("f1_min", min6, 2);
        chk("f1_sat", sat6, 0);
        take();

        foreach (pat[i]) send(pat[i], $urandom_range(0, 4));
        in_valid = 1'b1;
        in_count = 3'd7;
        repeat (5) step();
        in_valid = 1'b0;
        chk("f2_valid", out_valid, 1);
        chk("f2_total", total6, 15);
        chk("f2_max", max6, 4);
        chk("f2_min", min6, 0);
        take();

        frame(3'd4, 0);
        chk("sat_total4", total4, 15);
        chk("sat_sat4", sat4, 1);
        chk("sat_total6", total6, 32);
        take();
        frame(3'd1, 2);
        chk("unsat_total4", total4, 8);
        chk("unsat_sat4", sat4, 0);
        take();

        repeat (5) send(3'd5, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_ready", in_ready, 1);
        chk("abort_valid", out_valid, 0);
        frame(3'd3, 1);
        chk("fresh_total", total6, 24);
        chk("fresh_total4", total4, 15);
        take();

        out_ready = 1'b1;
        base = pulses;
        repeat (4 * N) send(3'd1, 0);
        repeat (3) step();
        out_ready = 1'b0;
        chk("b2b_pulses", pulses - base, 4);
        chk("b2b_total", total6, 8);

`ifdef ONES_FRAME_THRESH_EN
        repeat (7) send(3'd2, 0);
        send(3'd1, 0);
        chk("over15", over6, 0);
        take();
        frame(3'd2, 0);
        chk("over16", over6, 1);
        take();
        frame(3'd4, 0);
        chk("over32", over6, 1);
        take();
`endif

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
